pipeline_ctrl: RTL and testbench

Parametrised hazard and interrupt controller for the five-stage pipeline. It generalises the fixed 16-bit/32-bit-PC datapath control into a block sized by data width, PC width and register-address width. Functions:
- detects load-use hazards and stalls fetch/decode;
- flushes the front end on taken branches;
- sequences interrupt entry (drain, multi-word PC push, flag push, vector load) through an FSM with a ready/valid push handshake to the memory stage.

---
 rtl/pipeline_ctrl_if.sv | 11 +
 rtl/pipeline_ctrl.sv | 170 +++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_if.sv
// Push handshake from the hazard/interrupt controller to the memory stage.
interface pipeline_ctrl_if #(
  parameter int unsigned DATA_W = 16
);
  logic              int_push_valid;
  logic [DATA_W-1:0] int_push_data;
  logic              int_push_ready;

  modport master (output int_push_valid, output int_push_data, input int_push_ready);
  modport slave  (input int_push_valid, input int_push_data, output int_push_ready);
endinterface

// File: rtl/pipeline_ctrl.sv
// Load-use/branch hazard control plus interrupt entry sequencing for the 5-stage pipeline.
// The interrupt path is built only when PIPE_CTRL_INT_EN is defined.
module pipeline_ctrl #(
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned PC_W         = 32,
  parameter int unsigned REG_ADDR_W   = 3,
  parameter int unsigned FLAG_W       = 3,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  irq,
  input  logic [REG_ADDR_W-1:0] dec_rs1,
  input  logic [REG_ADDR_W-1:0] dec_rs2,
  input  logic                  dec_rs1_used,
  input  logic                  dec_rs2_used,
  input  logic                  dec_valid,
  input  logic [PC_W-1:0]       dec_pc,
  input  logic [PC_W-1:0]       fetch_pc,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rdest,
  input  logic                  branch_taken,
  input  logic [FLAG_W-1:0]     flags,
  output logic                  stall_fd,
  output logic                  flush_fd,
  output logic                  bubble_ex,
  output logic                  vector_load,
  output logic                  int_busy,
  pipeline_ctrl_if.master       push
);

  logic live_q;
  logic load_use;
  logic int_idle;
  logic int_hold;
  logic accept;

  // Outputs stay quiet during reset and for the first cycle after release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) live_q <= 1'b0;
    else      live_q <= 1'b1;
  end

  assign load_use = ex_mem_read & dec_valid &
                    ((dec_rs1_used & (dec_rs1 == ex_rdest)) |
                     (dec_rs2_used & (dec_rs2 == ex_rdest)));

  // Branch flush beats the load-use stall; an active interrupt sequence beats both.
  assign flush_fd  = live_q & int_idle & (branch_taken | accept);
  assign stall_fd  = live_q & (int_hold | (int_idle & ~branch_taken & load_use));
  assign bubble_ex = live_q & (int_hold | (int_idle & (branch_taken | load_use | accept)));

`ifdef PIPE_CTRL_INT_EN
  localparam int unsigned PC_WORDS = PC_W / DATA_W;
  localparam int unsigned IDX_W    = (PC_WORDS > 1) ? $clog2(PC_WORDS) : 1;
  localparam int unsigned CNT_W    = 4;

  typedef enum logic [2:0] {S_IDLE, S_DRAIN, S_PUSH_PC, S_PUSH_FLAGS, S_VECTOR} state_t;

  state_t            state_q, state_d;
  logic              irq_q;
  logic              irq_edge;
  logic              pending_q, pending_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [PC_W-1:0]   resume_pc_q, resume_pc_d;
  logic              push_valid;
  logic [DATA_W-1:0] push_data;
  logic              vec;
  logic              busy;

  assign irq_edge = live_q & irq & ~irq_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      irq_q       <= 1'b0;
      pending_q   <= 1'b0;
      cnt_q       <= '0;
      idx_q       <= '0;
      resume_pc_q <= '0;
    end else begin
      state_q     <= state_d;
      irq_q       <= irq;
      pending_q   <= pending_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      resume_pc_q <= resume_pc_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q | irq_edge;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    resume_pc_d = resume_pc_q;
    accept      = 1'b0;
    int_hold    = 1'b0;
    push_valid  = 1'b0;
    push_data   = '0;
    vec         = 1'b0;
    busy        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pending_q && !load_use && !branch_taken) begin
          accept      = 1'b1;
          pending_d   = irq_edge;
          resume_pc_d = dec_valid ? dec_pc : fetch_pc;
          cnt_d       = CNT_W'(DRAIN_CYCLES);
          state_d     = S_DRAIN;
        end
      end
      S_DRAIN: begin
        busy     = 1'b1;
        int_hold = 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          cnt_d   = '0;
          idx_d   = IDX_W'(PC_WORDS - 1);
          state_d = S_PUSH_PC;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_PUSH_PC: begin
        busy       = 1'b1;
        int_hold   = 1'b1;
        push_valid = 1'b1;
        push_data  = DATA_W'(resume_pc_q >> (DATA_W * 32'(idx_q)));
        if (push.int_push_ready) begin
          if (idx_q == '0) state_d = S_PUSH_FLAGS;
          else             idx_d   = idx_q - IDX_W'(1);
        end
      end
      S_PUSH_FLAGS: begin
        busy       = 1'b1;
        int_hold   = 1'b1;
        push_valid = 1'b1;
        push_data  = DATA_W'(flags);
        if (push.int_push_ready) state_d = S_VECTOR;
      end
      S_VECTOR: begin
        busy     = 1'b1;
        int_hold = 1'b1;
        vec      = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign int_idle            = (state_q == S_IDLE);
  assign vector_load         = vec;
  assign int_busy            = busy;
  assign push.int_push_valid = push_valid;
  assign push.int_push_data  = push_data;
`else
  logic unused_int;

  assign int_idle            = 1'b1;
  assign int_hold            = 1'b0;
  assign accept              = 1'b0;
  assign vector_load         = 1'b0;
  assign int_busy            = 1'b0;
  assign push.int_push_valid = 1'b0;
  assign push.int_push_data  = '0;
  assign unused_int          = ^{irq, dec_pc, fetch_pc, flags, push.int_push_ready};
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomized + directed bench for pipeline_ctrl against a queue-based reference model.
module tb_pipeline_ctrl;
`ifdef PIPE_CTRL_INT_EN
  localparam bit INT_EN = 1'b1;
`else
  localparam bit INT_EN = 1'b0;
`endif
  localparam int DATA_W   = 16;
  localparam int PC_W     = 32;
  localparam int RA_W     = 3;
  localparam int FLAG_W   = 3;
  localparam int DRAIN    = 3;
  localparam int PC_WORDS = PC_W / DATA_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              irq;
  logic [RA_W-1:0]   dec_rs1, dec_rs2, ex_rdest;
  logic              dec_rs1_used, dec_rs2_used, dec_valid;
  logic [PC_W-1:0]   dec_pc, fetch_pc;
  logic              ex_mem_read, branch_taken;
  logic [FLAG_W-1:0] flags;
  logic              stall_fd, flush_fd, bubble_ex, vector_load, int_busy;

  pipeline_ctrl_if #(.DATA_W(DATA_W)) push_if ();

  pipeline_ctrl #(
    .DATA_W(DATA_W), .PC_W(PC_W), .REG_ADDR_W(RA_W), .FLAG_W(FLAG_W), .DRAIN_CYCLES(DRAIN)
  ) dut (
    .clk(clk), .rst(rst), .irq(irq),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_rs1_used(dec_rs1_used), .dec_rs2_used(dec_rs2_used), .dec_valid(dec_valid),
    .dec_pc(dec_pc), .fetch_pc(fetch_pc),
    .ex_mem_read(ex_mem_read), .ex_rdest(ex_rdest), .branch_taken(branch_taken),
    .flags(flags),
    .stall_fd(stall_fd), .flush_fd(flush_fd), .bubble_ex(bubble_ex),
    .vector_load(vector_load), .int_busy(int_busy),
    .push(push_if.master)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a busy flag, a drain countdown and a queue of words still to push.
  bit          m_live, m_irq_prev, m_pending, m_busy;
  int          m_drain;
  int          m_q[$];
  logic        e_stall, e_flush, e_bubble, e_valid, e_vec, e_busy;
  logic [15:0] e_data;

  int          pushed[$];
  int          vec_cnt;
  int          hold_obs;

  function automatic bit hazard();
    return ex_mem_read && dec_valid &&
           ((dec_rs1_used && dec_rs1 == ex_rdest) || (dec_rs2_used && dec_rs2 == ex_rdest));
  endfunction

  task automatic model_reset();
    m_live = 0; m_irq_prev = 0; m_pending = 0; m_busy = 0; m_drain = 0;
    m_q.delete();
  endtask

  task automatic model_eval();
    e_stall = 0; e_flush = 0; e_bubble = 0; e_valid = 0; e_vec = 0; e_busy = 0; e_data = '0;
    if (m_live) begin
      if (m_busy) begin
        e_stall = 1; e_bubble = 1; e_busy = 1;
        if (m_drain == 0) begin
          if (m_q.size() > 0) begin
            e_valid = 1;
            e_data  = (m_q[0] < 0) ? 16'(flags) : 16'(m_q[0]);
          end else begin
            e_vec = 1;
          end
        end
      end else if (branch_taken) begin
        e_flush = 1; e_bubble = 1;
      end else if (hazard()) begin
        e_stall = 1; e_bubble = 1;
      end else if (INT_EN && m_pending) begin
        e_flush = 1; e_bubble = 1;
      end
    end
  endtask

  task automatic model_step();
    bit          edge_seen;
    logic [31:0] pc;
    if (!rst) begin
      model_reset();
      return;
    end
    edge_seen = INT_EN && m_live && irq && !m_irq_prev;
    if (!m_busy) begin
      if (INT_EN && m_live && m_pending && !branch_taken && !hazard()) begin
        m_busy  = 1;
        m_drain = DRAIN;
        pc      = dec_valid ? dec_pc : fetch_pc;
        m_q.delete();
        for (int w = PC_WORDS - 1; w >= 0; w--) m_q.push_back(int'(16'(pc >> (w * DATA_W))));
        m_q.push_back(-1);
        m_pending = edge_seen;
      end else begin
        m_pending = m_pending || edge_seen;
      end
    end else begin
      m_pending = m_pending || edge_seen;
      if (m_drain > 0) m_drain--;
      else if (m_q.size() > 0) begin
        if (push_if.int_push_ready) void'(m_q.pop_front());
      end else m_busy = 0;
    end
    m_irq_prev = irq;
    m_live     = 1;
  endtask

  // One clock: check at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    @(negedge clk);
    model_eval();
    check("stall_fd", 64'(stall_fd), 64'(e_stall));
    check("flush_fd", 64'(flush_fd), 64'(e_flush));
    check("bubble_ex", 64'(bubble_ex), 64'(e_bubble));
    check("push_valid", 64'(push_if.int_push_valid), 64'(e_valid));
    check("vector_load", 64'(vector_load), 64'(e_vec));
    check("int_busy", 64'(int_busy), 64'(e_busy));
    if (e_valid) check("push_data", 64'(push_if.int_push_data), 64'(e_data));
    if (push_if.int_push_valid && push_if.int_push_ready) pushed.push_back(int'(push_if.int_push_data));
    if (vector_load) vec_cnt++;
    if (push_if.int_push_valid && push_if.int_push_data == 16'h2345) hold_obs++;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic quiet_inputs();
    irq = 0; dec_rs1 = 0; dec_rs2 = 0; ex_rdest = 0; dec_rs1_used = 0; dec_rs2_used = 0;
    dec_valid = 0; dec_pc = 0; fetch_pc = 0; ex_mem_read = 0; branch_taken = 0; flags = 0;
    push_if.int_push_ready = 1;
  endtask

  task automatic check_seq(input string tag, input logic [31:0] pc, input logic [2:0] fl);
    int exp_w[3];
    exp_w[0] = int'(pc[31:16]); exp_w[1] = int'(pc[15:0]); exp_w[2] = int'(fl);
    check({tag, "_npush"}, 64'(pushed.size()), INT_EN ? 64'd3 : 64'd0);
    check({tag, "_nvec"}, 64'(vec_cnt), INT_EN ? 64'd1 : 64'd0);
    for (int i = 0; i < pushed.size() && i < 3; i++) check({tag, "_word"}, 64'(pushed[i]), 64'(exp_w[i]));
  endtask

  task automatic clear_obs();
    pushed.delete(); vec_cnt = 0; hold_obs = 0;
  endtask

  initial begin
    int stalls;
    int guard;
    quiet_inputs();
    rst = 0;
    model_reset();
    clear_obs();
    // Reset: hazard inputs active, outputs must still be zero
    ex_mem_read = 1; dec_valid = 1; dec_rs2 = 3; dec_rs2_used = 1; ex_rdest = 3;
    repeat (2) cycle();
    rst = 1;
    cycle();

    // Load-use hazard, then the same with the source unused
    cycle();
    dec_rs2_used = 0;
    cycle();
    // Branch together with a load-use match
    dec_rs2_used = 1; branch_taken = 1;
    cycle();
    quiet_inputs();
    cycle();

    // Interrupt entry with ready held high
    clear_obs();
    dec_valid = 1; dec_pc = 32'h0001_2345; flags = 3'b101;
    irq = 1;
    repeat (14) cycle();
    irq = 0;
    cycle();
    check_seq("entry", 32'h0001_2345, 3'b101);

    // Backpressure on the low PC word
    clear_obs();
    irq = 1;
    stalls = 0;
    for (int i = 0; i < 20; i++) begin
      model_eval();
      if (e_valid && e_data == 16'h2345 && stalls < 4) begin
        push_if.int_push_ready = 0; stalls++;
      end else push_if.int_push_ready = 1;
      cycle();
    end
    push_if.int_push_ready = 1;
    irq = 0;
    cycle();
    check_seq("bp", 32'h0001_2345, 3'b101);
    check("bp_hold", 64'(hold_obs), INT_EN ? 64'd5 : 64'd0);

    // Deferred acceptance behind a taken branch
    clear_obs();
    dec_pc = 32'hABCD_0042;
    irq = 1;
    cycle();
    branch_taken = 1;
    cycle();
    branch_taken = 0;
    repeat (12) cycle();
    irq = 0;
    cycle();
    check_seq("defer", 32'hABCD_0042, 3'b101);

    // Reset in the middle of the PC push, irq held high across release
    clear_obs();
    irq = 1;
    guard = 0;
    cycle();
    while (INT_EN && !(m_busy && m_drain == 0 && m_q.size() == PC_WORDS) && guard < 20) begin
      cycle(); guard++;
    end
    check("mid_reach", 64'(guard < 20), 64'd1);
    rst = 0;
    model_reset();
    cycle();
    rst = 1;
    clear_obs();
    repeat (15) cycle();
    check("noedge_push", 64'(pushed.size()), 64'd0);
    irq = 0;
    cycle();
    dec_pc = 32'h0007_8001; flags = 3'b010;
    irq = 1;
    repeat (14) cycle();
    irq = 0;
    cycle();
    check_seq("post_rst", 32'h0007_8001, 3'b010);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      dec_rs1 = RA_W'($urandom); dec_rs2 = RA_W'($urandom); ex_rdest = RA_W'($urandom);
      dec_rs1_used = 1'($urandom); dec_rs2_used = 1'($urandom); dec_valid = 1'($urandom);
      ex_mem_read = ($urandom_range(0, 1) == 0);
      branch_taken = ($urandom_range(0, 6) == 0);
      dec_pc = $urandom; fetch_pc = $urandom; flags = FLAG_W'($urandom);
      if ($urandom_range(0, 9) == 0) irq = ~irq;
      push_if.int_push_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 499) == 0) begin
        rst = 0; model_reset();
        cycle();
        rst = 1;
      end
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
